operand_fetch: RTL and testbench

- Operand-fetch stage that sits between instruction fetch and execute in the 16-bit / 6-bit-address CPU.
- Takes the first instruction word, resolves the destination address, and reads the source operand values from data memory.
- Supports direct (mem[a]) and indirect (mem[mem[a][5:0]]) addressing.
- Hands resolved operands to the execute stage with a start/done handshake.

---
 rtl/operand_fetch.sv | 117 +++++++++++
 tb/tb_operand_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: resolves the destination address and reads the source operands from data memory (direct or indirect addressing).
// Define OPFETCH_TRACE_EN to add the saturating rd_count read counter.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ir_word,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] op_c,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef OPFETCH_TRACE_EN
  ,
  output logic [15:0]           rd_count
`endif
);
  typedef enum logic [2:0] {
    IDLE, DPTR_ADDR, DPTR_DATA, SRC_ADDR, SRC_DATA, SRC_IND, SRC_IND_DATA, DONE
  } state_t;
  function automatic logic has_dst(input logic [3:0] oc);
    return oc <= 4'd4 || oc == 4'd7;
  endfunction
  function automatic logic has_b(input logic [3:0] oc);
    return oc <= 4'd4 || oc == 4'd8;
  endfunction
  function automatic logic has_c(input logic [3:0] oc);
    return oc >= 4'd1 && oc <= 4'd4;
  endfunction
  function automatic logic legal(input logic [3:0] oc);
    return has_dst(oc) || has_b(oc) || oc == 4'd15;
  endfunction
  state_t                state_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic                  sel_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic [3:0]            oc_i;
  logic [3:0]            oc_q;
  logic                  cur_di;
  logic [2:0]            cur_a;
  assign oc_i = ir_word[15:12];
  assign oc_q = ir_q[15:12];
  // out takes its B operand from field 1; everything else uses field 2 for B and field 3 for C
  assign cur_di = sel_q ? ir_q[3] : (oc_q == 4'd8 ? ir_q[11] : ir_q[7]);
  assign cur_a  = sel_q ? ir_q[2:0] : (oc_q == 4'd8 ? ir_q[10:8] : ir_q[6:4]);
  always_comb
    mem_addr = state_q == DPTR_ADDR ? ADDR_WIDTH'(ir_q[10:8]) :
               state_q == SRC_ADDR  ? ADDR_WIDTH'(cur_a) :
               state_q == SRC_IND   ? ptr_q : '0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign err      = done && err_q;
  assign dst_addr = dst_q;
  assign op_b     = b_q;
  assign op_c     = c_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      dst_q   <= '0;
      ptr_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          ir_q    <= ir_word;
          sel_q   <= 1'b0;
          err_q   <= !legal(oc_i);
          dst_q   <= (has_dst(oc_i) && !ir_word[11]) ? ADDR_WIDTH'(ir_word[10:8]) : '0;
          b_q     <= '0;
          c_q     <= '0;
          state_q <= (has_dst(oc_i) && ir_word[11]) ? DPTR_ADDR : has_b(oc_i) ? SRC_ADDR : DONE;
        end
        DPTR_ADDR: state_q <= DPTR_DATA;
        DPTR_DATA: begin
          dst_q   <= mem_rdata[ADDR_WIDTH-1:0];
          state_q <= has_b(oc_q) ? SRC_ADDR : DONE;
        end
        SRC_ADDR: state_q <= SRC_DATA;
        SRC_IND:  state_q <= SRC_IND_DATA;
        SRC_DATA, SRC_IND_DATA: begin
          if (state_q == SRC_DATA && cur_di) begin
            ptr_q   <= mem_rdata[ADDR_WIDTH-1:0];
            state_q <= SRC_IND;
          end else begin
            if (sel_q) c_q <= mem_rdata;
            else b_q <= mem_rdata;
            sel_q   <= 1'b1;
            state_q <= (!sel_q && has_c(oc_q)) ? SRC_ADDR : DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef OPFETCH_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_count <= '0;
    else if ((state_q == SRC_ADDR || state_q == SRC_IND || state_q == DPTR_ADDR) && rd_count != 16'hFFFF)
      rd_count <= rd_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors against a 1-cycle-latency memory model; a scoreboard queue is checked by a done-driven monitor.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir_word = '0;
  logic        busy, done, err;
  logic [5:0]  dst_addr, mem_addr;
  logic [15:0] op_b, op_c;
  logic [15:0] mem_rdata = '0;
`ifdef OPFETCH_TRACE_EN
  logic [15:0] rd_count;
`endif
  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir_word(ir_word),
    .busy(busy), .done(done), .err(err), .dst_addr(dst_addr),
    .op_b(op_b), .op_c(op_c), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef OPFETCH_TRACE_EN
    , .rd_count(rd_count)
`endif
  );
  always #5 clk = ~clk;
  logic [15:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1] = 16'h0005;
    mem[2] = 16'h0007;
    mem[3] = 16'h0020;
    mem[32] = 16'h1234;
  end
  always @(posedge clk) mem_rdata <= mem[mem_addr];
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [5:0]  dst;
    logic [15:0] b;
    logic [15:0] c;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("dst_addr", 32'(dst_addr), 32'(e.dst));
        chk("op_b", 32'(op_b), 32'(e.b));
        chk("op_c", 32'(op_c), 32'(e.c));
        chk("err", 32'(err), 32'(e.e));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end
  task automatic run(input logic [15:0] ir, input logic [5:0] d, input logic [15:0] b,
                     input logic [15:0] c, input logic e, input int lat,
                     input logic [5:0] m1, input int m3, input bit hold);
    exp_t x;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ir_word = ir;
    x = '{d, b, c, e, lat, cyc};
    q.push_back(x);
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) begin
        chk("mem_addr_t1", 32'(mem_addr), 32'(m1));
        chk("busy_t1", 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
      end
      if (k == 3 && m3 >= 0) chk("mem_addr_t3", 32'(mem_addr), 32'(m3));
      if (hold && k == 2) ir_word = 16'h5000;
      if (q.size() == 0) begin
        seen = 1'b1;
        start = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout ir=%0h actual=no_done required=done", ir);
      q.delete();
      start = 1'b0;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dst", 32'(dst_addr), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_c", 32'(op_c), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    run(16'h1123, 6'd1, 16'h0007, 16'h0020, 1'b0, 5, 6'd2, 3, 1'b0);
    run(16'h0BB0, 6'h20, 16'h1234, 16'h0000, 1'b0, 7, 6'd3, 3, 1'b0);
`ifdef OPFETCH_TRACE_EN
    #1;
    chk("rd_count", 32'(rd_count), 32'd5);
`endif
    run(16'h8200, 6'd0, 16'h0007, 16'h0000, 1'b0, 3, 6'd2, -1, 1'b0);
    run(16'h7100, 6'd1, 16'h0000, 16'h0000, 1'b0, 1, 6'd0, -1, 1'b0);
    run(16'h5000, 6'd0, 16'h0000, 16'h0000, 1'b1, 1, 6'd0, -1, 1'b0);
    run(16'hF000, 6'd0, 16'h0000, 16'h0000, 1'b0, 1, 6'd0, -1, 1'b0);
    run(16'h112B, 6'd1, 16'h0007, 16'h1234, 1'b0, 7, 6'd2, 3, 1'b0);
    run(16'h1123, 6'd1, 16'h0007, 16'h0020, 1'b0, 5, 6'd2, 3, 1'b1);
    @(negedge clk);
    start = 1'b1;
    ir_word = 16'h1123;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dst", 32'(dst_addr), 32'd0);
    chk("abort_op_b", 32'(op_b), 32'd0);
    chk("abort_op_c", 32'(op_c), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("no_done_after_abort", 32'(done), 32'd0);
    run(16'h1123, 6'd1, 16'h0007, 16'h0020, 1'b0, 5, 6'd2, 3, 1'b0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
